hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard detection for a 5-stage MIPS-style core.
//
// Raises stall (and the matching E_flush bubble) when the instruction in D
// needs a register value that E or M will not have produced in time
// (Tuse/Tnew scheme), or when D touches the mult/div unit while it is busy
// or being started.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   D_rs_addr, D_rt_addr       source registers of the instruction in D
//   D_Tuse_rs, D_Tuse_rt       cycles until D needs rs/rt (all-ones = unused)
//   D_md_use                   D is a mult/div/mfhi/mflo/mthi/mtlo
//   E_A3/M_A3, E_WE/M_WE       destination register and write enable in E/M
//   E_Tnew, M_Tnew             cycles until the E/M result is available
//   E_md_start, E_md_div       E starts mult (div=0) or div (div=1)
//   perf_clr                   synchronous clear of stall_cnt
//   stall, E_flush             freeze PC + F/D, bubble into D/E
//   md_busy                    mult/div unit is computing
//   stall_cnt                  stall-cycle counter
//
// Build option: define HAZARD_PERF_EN to get a saturating stall_cnt.
// Without it stall_cnt is tied to 0 and perf_clr is ignored.

module hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int T_W         = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] D_rs_addr,
    input  logic [REG_AW-1:0] D_rt_addr,
    input  logic [T_W-1:0]    D_Tuse_rs,
    input  logic [T_W-1:0]    D_Tuse_rt,
    input  logic              D_md_use,
    input  logic [REG_AW-1:0] E_A3,
    input  logic [REG_AW-1:0] M_A3,
    input  logic              E_WE,
    input  logic              M_WE,
    input  logic [T_W-1:0]    E_Tnew,
    input  logic [T_W-1:0]    M_Tnew,
    input  logic              E_md_start,
    input  logic              E_md_div,
    input  logic              perf_clr,
    output logic              stall,
    output logic              E_flush,
    output logic              md_busy,
    output logic [31:0]       stall_cnt
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    logic [CNT_W-1:0] md_cnt;
    logic             haz_rs;
    logic             haz_rt;
    logic             haz_md;

    // One producer vs one consumer operand. Tnew == 0 can never exceed a
    // Tuse, and an all-ones Tuse can never be below a Tnew, so both the
    // "already available" and "operand unused" cases fall out naturally.
    function automatic logic prod_haz(
        input logic [REG_AW-1:0] src,
        input logic [T_W-1:0]    tuse,
        input logic [REG_AW-1:0] a3,
        input logic              we,
        input logic [T_W-1:0]    tnew
    );
        return (tuse < tnew) && (src == a3) && (a3 != '0) && we;
    endfunction

    always_comb begin
        haz_rs = prod_haz(D_rs_addr, D_Tuse_rs, E_A3, E_WE, E_Tnew)
               | prod_haz(D_rs_addr, D_Tuse_rs, M_A3, M_WE, M_Tnew);
        haz_rt = prod_haz(D_rt_addr, D_Tuse_rt, E_A3, E_WE, E_Tnew)
               | prod_haz(D_rt_addr, D_Tuse_rt, M_A3, M_WE, M_Tnew);
        // E_md_start counts too: md_busy only rises on the following cycle.
        haz_md = D_md_use & (md_busy | E_md_start);
    end

    assign stall   = haz_rs | haz_rt | haz_md;
    assign E_flush = stall;

    // Mult/div countdown; a new start always reloads, even mid-operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (E_md_start) begin
            md_cnt <= E_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    // Decoded straight from the counter flops, so busy spans exactly the
    // loaded count starting the cycle after the start.
    assign md_busy = (md_cnt != '0);

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign stall_cnt       = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, all compared against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int T_W    = 2;
    localparam int MULT   = 5;
    localparam int DIV    = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] D_rs_addr, D_rt_addr, E_A3, M_A3;
    logic [T_W-1:0]    D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
    logic              D_md_use, E_WE, M_WE, E_md_start, E_md_div, perf_clr;
    logic              stall, E_flush, md_busy;
    logic [31:0]       stall_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model state: cycle index, last MD start and its length,
    // and the number of stalling edges since the last clear.
    int     cyc     = 0;
    int     start_c = -1;
    int     md_len  = 0;
    longint scnt    = 0;

    hazard_ctrl #(
        .REG_AW(REG_AW), .T_W(T_W), .MULT_CYCLES(MULT), .DIV_CYCLES(DIV)
    ) dut (
        .clk(clk), .reset(reset),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_md_use(D_md_use),
        .E_A3(E_A3), .M_A3(M_A3), .E_WE(E_WE), .M_WE(M_WE),
        .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
        .E_md_start(E_md_start), .E_md_div(E_md_div), .perf_clr(perf_clr),
        .stall(stall), .E_flush(E_flush), .md_busy(md_busy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit m_busy();
        if (!reset || start_c < 0) return 1'b0;
        return (cyc > start_c) && (cyc <= start_c + md_len);
    endfunction

    // A producer blocks a consumer if it writes a nonzero register that
    // matches and delivers later than the consumer needs it.
    function automatic bit blocks(int src, int tuse, int a3, bit we, int tnew);
        return we && a3 != 0 && src == a3 && tuse < tnew;
    endfunction

    function automatic bit m_stall();
        bit h;
        h = blocks(int'(D_rs_addr), int'(D_Tuse_rs), int'(E_A3), E_WE, int'(E_Tnew))
          | blocks(int'(D_rs_addr), int'(D_Tuse_rs), int'(M_A3), M_WE, int'(M_Tnew))
          | blocks(int'(D_rt_addr), int'(D_Tuse_rt), int'(E_A3), E_WE, int'(E_Tnew))
          | blocks(int'(D_rt_addr), int'(D_Tuse_rt), int'(M_A3), M_WE, int'(M_Tnew));
        return h | (D_md_use && (m_busy() || E_md_start));
    endfunction

    function automatic logic [31:0] m_cnt();
`ifdef HAZARD_PERF_EN
        if (!reset) return 32'd0;
        return (scnt > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : scnt[31:0];
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        D_rs_addr = '0; D_rt_addr = '0; D_Tuse_rs = '1; D_Tuse_rt = '1;
        D_md_use = 0; E_A3 = '0; M_A3 = '0; E_WE = 0; M_WE = 0;
        E_Tnew = '0; M_Tnew = '0; E_md_start = 0; E_md_div = 0; perf_clr = 0;
    endtask

    // Called just after a falling edge with inputs applied: check, clock, advance model.
    task automatic step(input string tag);
        bit e;
        #1;
        e = m_stall();
        chk({tag, ".stall"}, 32'(stall), 32'(e));
        chk({tag, ".E_flush"}, 32'(E_flush), 32'(e));
        chk({tag, ".md_busy"}, 32'(md_busy), 32'(m_busy()));
        chk({tag, ".stall_cnt"}, stall_cnt, m_cnt());
        @(posedge clk);
        if (!reset) begin
            start_c = -1;
            scnt    = 0;
        end else begin
            if (E_md_start) begin
                start_c = cyc;
                md_len  = E_md_div ? DIV : MULT;
            end
`ifdef HAZARD_PERF_EN
            if (perf_clr) scnt = 0;
            else if (e) scnt++;
`endif
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic assert_reset();
        reset   = 1'b0;
        start_c = -1;
        scnt    = 0;
    endtask

    initial begin
        int nst;
        idle();
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst.md_busy", 32'(md_busy), 32'd0);
        chk("rst.stall_cnt", stall_cnt, 32'd0);
        step("rst");
        reset = 1'b1;
        step("idle");

        // Load-use from E, then the same with the zero register.
        E_A3 = 5'd8; E_WE = 1; E_Tnew = 2'd2; D_rs_addr = 5'd8; D_Tuse_rs = 2'd1;
        #1; chk("loaduse.stall_const", 32'(stall), 32'd1);
        chk("loaduse.flush_const", 32'(E_flush), 32'd1);
        step("loaduse");
        E_A3 = 5'd0; D_rs_addr = 5'd0;
        #1; chk("loaduse_r0.stall_const", 32'(stall), 32'd0);
        step("loaduse_r0");
        idle();

        // Store data from M: needed later (no stall) vs needed now (stall).
        M_A3 = 5'd9; M_WE = 1; M_Tnew = 2'd1; D_rt_addr = 5'd9; D_Tuse_rt = 2'd2;
        #1; chk("store_late.stall_const", 32'(stall), 32'd0);
        step("store_late");
        D_Tuse_rt = 2'd0;
        #1; chk("store_now.stall_const", 32'(stall), 32'd1);
        step("store_now");
        idle();

        // Divide: busy for DIV cycles, stall for DIV+1 with D_md_use held.
        nst = 0;
        D_md_use = 1; E_md_start = 1; E_md_div = 1;
        #1; nst += int'(stall);
        step("div_start");
        E_md_start = 0; E_md_div = 0;
        for (int i = 0; i < DIV + 2; i++) begin
            #1; nst += int'(stall);
            step("div_run");
        end
        chk("div.stall_cycles", 32'(nst), 32'(DIV + 1));
        idle();

        // Mult then a reset pulse two cycles in aborts the countdown.
        E_md_start = 1;
        step("mult_start");
        E_md_start = 0;
        step("mult_run");
        assert_reset();
        #1; chk("mult_rst.md_busy_now", 32'(md_busy), 32'd0);
        #3; step("mult_rst");
        reset = 1'b1;
        for (int i = 0; i < MULT; i++) step("mult_after");
        D_md_use = 1;
        step("mult_after_use");
        idle();

        // Seven stalling edges, then a clear that coincides with a stall.
        E_A3 = 5'd3; E_WE = 1; E_Tnew = 2'd1; D_rs_addr = 5'd3; D_Tuse_rs = 2'd0;
        for (int i = 0; i < 7; i++) step("perf_stall");
`ifdef HAZARD_PERF_EN
        chk("perf.cnt7", stall_cnt, 32'd7);
`else
        chk("perf.cnt_off", stall_cnt, 32'd0);
`endif
        perf_clr = 1;
        step("perf_clr");
        perf_clr = 0;
        chk("perf.cleared", stall_cnt, 32'd0);
        idle();

        // Random traffic over a small register window so matches are common.
        for (int i = 0; i < 400; i++) begin
            D_rs_addr  = 5'($urandom_range(0, 3));
            D_rt_addr  = 5'($urandom_range(0, 3));
            E_A3       = 5'($urandom_range(0, 3));
            M_A3       = 5'($urandom_range(0, 3));
            D_Tuse_rs  = 2'($urandom_range(0, 3));
            D_Tuse_rt  = 2'($urandom_range(0, 3));
            E_Tnew     = 2'($urandom_range(0, 3));
            M_Tnew     = 2'($urandom_range(0, 3));
            E_WE       = 1'($urandom_range(0, 1));
            M_WE       = 1'($urandom_range(0, 1));
            D_md_use   = ($urandom_range(0, 3) == 0);
            E_md_start = ($urandom_range(0, 9) == 0);
            E_md_div   = 1'($urandom_range(0, 1));
            perf_clr   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) begin
                assert_reset();
                step("rand_rst");
                reset = 1'b1;
            end else begin
                step("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
